// File: rtl/sms_pkg.sv
// Shared definitions for the save-state backup sequencer.
package sms_pkg;

  // Sequencer phases: idle, waiting for the sector ack to rise, waiting for it to fall.
  typedef enum logic [1:0] {
    BK_IDLE,
    BK_REQ,
    BK_ACK
  } bk_state_t;

  // One SD sector as seen through the hps_io buffer.
  localparam int SECTOR_BYTES = 512;

endpackage : sms_pkg

// File: rtl/sms_bk_sequencer.sv
// Save-state sector sequencer: walks the sectors of one save slot through the
// hps_io SD buffer, forms backup RAM addresses and reports busy/done/error.
module sms_bk_sequencer
  import sms_pkg::*;
#(
  parameter int          SECT_LOG2 = 6,
  parameter int          SLOT_BITS = 2,
  parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            download,
  input  logic                            img_mounted,
  input  logic                            img_readonly,
  input  logic                            img_size_nz,
  input  logic                            load_req,
  input  logic                            save_req,
  input  logic [SLOT_BITS-1:0]            slot,
  output logic [31:0]                     sd_lba,
  output logic                            sd_rd,
  output logic                            sd_wr,
  input  logic                            sd_ack,
  input  logic [$clog2(SECTOR_BYTES)-1:0] sd_buff_addr,
  input  logic                            sd_buff_wr,
  output logic [SECT_LOG2+$clog2(SECTOR_BYTES)-1:0] bk_addr,
  output logic                            bk_we,
  output logic                            bk_ena,
  output logic                            bk_busy,
  output logic                            bk_loading,
  output logic                            bk_done,
  output logic                            bk_err
);

  bk_state_t   state, state_n;
  logic [23:0] timer, timer_n;
  logic [31:0] sd_lba_n;
  logic        sd_rd_n, sd_wr_n;
  logic        bk_busy_n, bk_loading_n, bk_done_n, bk_err_n;

  logic old_download, old_load, old_save, old_ack;
  logic load_rise, save_rise, ack_rise, ack_fall, last_sector;

  // Edge qualifiers; request edges only count while a writable image is mounted.
  assign load_rise   = bk_ena & load_req & ~old_load;
  assign save_rise   = bk_ena & save_req & ~old_save;
  assign ack_rise    = sd_ack & ~old_ack;
  assign ack_fall    = ~sd_ack & old_ack;
  assign last_sector = &sd_lba[SECT_LOG2-1:0];

  // RAM-side signals pass straight through so writes line up with sd_buff_wr.
  assign bk_we   = sd_buff_wr & sd_ack;
  assign bk_addr = {sd_lba[SECT_LOG2-1:0], sd_buff_addr};

  // Mount tracking: a new download invalidates the image unless it is mounted writable in that same cycle.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      bk_ena       <= 1'b0;
      old_download <= 1'b0;
    end else begin
      old_download <= download;
      if (download & img_mounted & img_size_nz & ~img_readonly)
        bk_ena <= 1'b1;
      else if (download & ~old_download)
        bk_ena <= 1'b0;
    end
  end

  // Edge-detect history for the requests and the hps_io acknowledge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_load <= 1'b0;
      old_save <= 1'b0;
      old_ack  <= 1'b0;
    end else begin
      old_load <= load_req & bk_ena;
      old_save <= save_req & bk_ena;
      old_ack  <= sd_ack;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_sys) begin
    // NOTE: the reset here is synchronous; every register in this block is plain flop state, none is a memory.
    if (reset) begin
      state      <= BK_IDLE;
      timer      <= '0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_busy    <= 1'b0;
      bk_loading <= 1'b0;
      bk_done    <= 1'b0;
      bk_err     <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      sd_lba     <= sd_lba_n;
      sd_rd      <= sd_rd_n;
      sd_wr      <= sd_wr_n;
      bk_busy    <= bk_busy_n;
      bk_loading <= bk_loading_n;
      bk_done    <= bk_done_n;
      bk_err     <= bk_err_n;
    end
  end

  // Next-state logic: accept a request, wait for each sector's ack rise then fall, advance or finish.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_n      = state;
    timer_n      = timer;
    sd_lba_n     = sd_lba;
    sd_rd_n      = sd_rd;
    sd_wr_n      = sd_wr;
    bk_busy_n    = bk_busy;
    bk_loading_n = bk_loading;
    bk_done_n    = 1'b0;
    bk_err_n     = 1'b0;

    unique case (state)
      BK_IDLE: begin
        if (load_rise | save_rise) begin
          // A simultaneous load and save edge resolves to load.
          state_n      = BK_REQ;
          sd_lba_n     = 32'({slot, {SECT_LOG2{1'b0}}});
          sd_rd_n      = load_rise;
          sd_wr_n      = ~load_rise;
          bk_busy_n    = 1'b1;
          bk_loading_n = load_rise;
          timer_n      = '0;
        end
      end

      BK_REQ: begin
        if (ack_rise) begin
          sd_rd_n = 1'b0;
          sd_wr_n = 1'b0;
          state_n = BK_ACK;
        end else if (timer == TIMEOUT - 24'd1) begin
          // hps_io never picked the sector up: abandon the whole transfer.
          state_n      = BK_IDLE;
          sd_rd_n      = 1'b0;
          sd_wr_n      = 1'b0;
          bk_busy_n    = 1'b0;
          bk_loading_n = 1'b0;
          bk_err_n     = 1'b1;
        end else begin
          timer_n = timer + 24'd1;
        end
      end

      BK_ACK: begin
        // No timeout here: once hps_io acks a sector it always finishes it.
        if (ack_fall) begin
          if (last_sector) begin
            state_n      = BK_IDLE;
            bk_busy_n    = 1'b0;
            bk_loading_n = 1'b0;
            bk_done_n    = 1'b1;
          end else begin
            state_n  = BK_REQ;
            sd_lba_n = sd_lba + 32'd1;
            sd_rd_n  = bk_loading;
            sd_wr_n  = ~bk_loading;
            timer_n  = '0;
          end
        end
      end

      default: state_n = BK_IDLE;
    endcase
  end

endmodule : sms_bk_sequencer

// File: tb/tb_sms_bk_sequencer.sv
// Self-checking bench for sms_bk_sequencer: randomized hps_io responses checked
// against a sector-level model of the save/load protocol.
module tb_sms_bk_sequencer;
  import sms_pkg::*;

  localparam int          SECT_LOG2 = 6;
  localparam int          SLOT_BITS = 2;
  localparam int          NSECT     = 1 << SECT_LOG2;
  localparam logic [23:0] TO        = 24'd100;

  logic        clk_sys = 1'b0;
  logic        reset, download, img_mounted, img_readonly, img_size_nz;
  logic        load_req, save_req, sd_ack, sd_buff_wr;
  logic [SLOT_BITS-1:0] slot;
  logic [8:0]  sd_buff_addr;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_we, bk_ena, bk_busy, bk_loading, bk_done, bk_err;
  logic [SECT_LOG2+8:0] bk_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural mount model.
  bit m_ena     = 1'b0;
  bit m_prev_dl = 1'b0;

  sms_bk_sequencer #(.SECT_LOG2(SECT_LOG2), .SLOT_BITS(SLOT_BITS), .TIMEOUT(TO)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .download     (download),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size_nz  (img_size_nz),
    .load_req     (load_req),
    .save_req     (save_req),
    .slot         (slot),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .bk_addr      (bk_addr),
    .bk_we        (bk_we),
    .bk_ena       (bk_ena),
    .bk_busy      (bk_busy),
    .bk_loading   (bk_loading),
    .bk_done      (bk_done),
    .bk_err       (bk_err)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; the mount model consumes the inputs presented to this edge.
  task automatic step();
    if (reset) begin
      m_ena     = 1'b0;
      m_prev_dl = 1'b0;
    end else begin
      if (download && img_mounted && img_size_nz && !img_readonly) m_ena = 1'b1;
      else if (download && !m_prev_dl)                              m_ena = 1'b0;
      m_prev_dl = download;
    end
    @(negedge clk_sys);
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_lba"},  sd_lba, 32'd0);
    check({tag, "_rdwr"}, {sd_rd, sd_wr}, 0);
    check({tag, "_busy"}, {bk_busy, bk_loading, bk_done, bk_err}, 0);
    check({tag, "_ena"},  bk_ena, m_ena);
  endtask

  task automatic mount(input bit ro);
    download = 1'b0; step();
    download = 1'b1; img_size_nz = 1'b1; img_readonly = ro; step();
    check("ena_dl_rise", bk_ena, m_ena);
    img_mounted = 1'b1; step();
    img_mounted = 1'b0;
    check("ena_mount", bk_ena, m_ena);
    repeat (2) step();
    download = 1'b0; step();
    check("ena_hold", bk_ena, m_ena);
  endtask

  // One transfer of a whole slot as seen from the hps_io side.
  task automatic xfer(input bit is_load, input int slot_n, input int stop_at,
                      input bit both, input bit mid_save);
    int base;
    int n;
    bit special;
    base = slot_n * NSECT;
    slot = SLOT_BITS'(slot_n);
    if (both) begin
      load_req = 1'b1; save_req = 1'b1;
    end else if (is_load) load_req = 1'b1;
    else                  save_req = 1'b1;
    step();
    load_req = 1'b0; save_req = 1'b0;
    for (int i = 0; i < NSECT; i++) begin
      check("lba",     sd_lba, 32'(base + i));
      check("rd",      sd_rd, is_load);
      check("wr",      sd_wr, !is_load);
      check("busy",    bk_busy, 1'b1);
      check("loading", bk_loading, is_load);
      if (i == stop_at) return;
      if (mid_save && i == 3) save_req = 1'b1;
      n = $urandom_range(0, 3);
      repeat (n) begin
        sd_buff_wr = 1'($urandom_range(0, 1));
        #1 check("we_noack", bk_we, 1'b0);
        step();
        check("req_hold", sd_rd | sd_wr, 1'b1);
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b1; step();
      check("req_drop", {sd_rd, sd_wr}, 0);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        special = is_load && slot_n == 0 && i == 5 && k == 0;
        sd_buff_addr = special ? 9'd3 : 9'($urandom_range(0, SECTOR_BYTES - 1));
        sd_buff_wr   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1 check("we", bk_we, sd_buff_wr);
        if (sd_buff_wr) check("addr", bk_addr, 32'(i * SECTOR_BYTES + int'(sd_buff_addr)));
        if (special)    check("addr_a03", bk_addr, 32'hA03);
        step();
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0; step();
      if (i == NSECT - 1) begin
        check("done",      bk_done, 1'b1);
        check("end_busy",  {bk_busy, bk_loading}, 0);
        check("end_rdwr",  {sd_rd, sd_wr}, 0);
      end else begin
        check("no_done",   bk_done, 1'b0);
      end
    end
    step();
    check("done_pulse", bk_done, 1'b0);
  endtask

  initial begin
    int k;
    reset = 1'b1; download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    img_size_nz = 1'b0; load_req = 1'b0; save_req = 1'b0; slot = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_wr = 1'b0;
    step(); step();
    check_all_idle("reset");
    reset = 1'b0; step();

    // Read-only image never enables backup; a request is then ignored.
    mount(1'b1);
    check("ena_ro", bk_ena, 1'b0);
    save_req = 1'b1; repeat (3) step();
    check("ignored_busy", {bk_busy, sd_wr}, 0);
    save_req = 1'b0; step();

    // Writable image enables backup.
    mount(1'b0);
    check("ena_rw", bk_ena, 1'b1);

    // Save slot 2: lba 0x80..0xBF.
    xfer(1'b0, 2, -1, 1'b0, 1'b0);
    // Load slot 0, including the 0xA03 write.
    xfer(1'b1, 0, -1, 1'b0, 1'b0);
    // Simultaneous edges resolve to load; a save edge mid-load is dropped.
    xfer(1'b1, 1, -1, 1'b1, 1'b1);
    repeat (5) begin
      step();
      check("no_second_xfer", {bk_busy, sd_wr, sd_rd}, 0);
    end
    save_req = 1'b0; step();

    // Timeout: no ack ever arrives.
    slot = 2'd3; load_req = 1'b1; step();
    load_req = 1'b0;
    check("to_rd", sd_rd, 1'b1);
    k = 0;
    while (!bk_err && k < 200) begin
      step();
      k++;
    end
    check("to_cycle", k, 32'(TO));
    check("to_rd_clr", {sd_rd, sd_wr}, 0);
    check("to_busy_clr", {bk_busy, bk_loading}, 0);
    step();
    check("to_err_pulse", bk_err, 1'b0);

    // Reset in the middle of a transfer.
    xfer(1'b1, 3, 10, 1'b0, 1'b0);
    reset = 1'b1; step();
    reset = 1'b0;
    check_all_idle("midreset");
    mount(1'b0);
    xfer(1'b0, 1, -1, 1'b0, 1'b0);

    // Randomized transfers.
    repeat (3) xfer(1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sms_bk_sequencer
